// File: rtl/memoria_dados_param.sv
// memoria_dados_param: parametrised single-port data memory with a
// request/response handshake and a sequential clear engine.
// After reset, and whenever clear_req is seen in IDLE, the engine writes
// zero to one word per clock until all DEPTH words are cleared.
// Optional build macro: MEMORIA_RANGE_CHECK_EN flags out-of-range
// accepted requests on rsp_err; without it rsp_err is always 0.
//
// Handshake: a request is accepted on a rising edge when req_valid and
// req_ready are both high. req_ready is high only in IDLE with clear_req
// low. Every accepted request produces exactly one rsp_valid pulse in the
// following cycle; there is no response back-pressure. rsp_rdata and
// rsp_err hold their last value while rsp_valid is low.
module memoria_dados_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              clear_req,
  output logic              busy,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  cnt_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              in_range;

  // Address decode: the low bits index the array, the full address decides range.
  assign idx      = req_addr[IDX_W-1:0];
  assign in_range = ({1'b0, req_addr} < DEPTH_L);
  assign accept   = req_valid & req_ready;

  // Next state, clear counter and handshake outputs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    busy       = 1'b0;
    req_ready  = 1'b0;
    case (state)
      S_CLEAR: begin
        busy = 1'b1;
        if (cnt == LAST_IDX) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        req_ready = ~clear_req;
        if (clear_req) begin
          state_next = S_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // State register; reset restarts the clear sweep from word 0.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Storage: the clear engine owns the write port while sweeping.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[cnt] <= '0;
    end else if (accept && req_we && in_range) begin
      mem[idx] <= req_wdata;
    end
  end

  // Registered response; read data is the content before this edge's write.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        if (!in_range) begin
          rsp_rdata <= '0;
        end else if (req_we) begin
          rsp_rdata <= req_wdata;
        end else begin
          rsp_rdata <= mem[idx];
        end
`ifdef MEMORIA_RANGE_CHECK_EN
        rsp_err <= ~in_range;
`else
        rsp_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_memoria_dados_param.sv
// Bench for memoria_dados_param: a DEPTH=256 instance for clear, fill,
// on-demand clear and reset-restart sequences, and a DEPTH=200 instance
// driven from a vector table for the out-of-range behaviour.
module tb_memoria_dados_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic clr;

`ifdef MEMORIA_RANGE_CHECK_EN
  localparam logic OOR_ERR = 1'b1;
`else
  localparam logic OOR_ERR = 1'b0;
`endif

  // DEPTH=256 instance
  logic       clear_req, busy, req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata, rsp_rdata;
  logic       rsp_valid, rsp_err;

  // DEPTH=200 instance
  logic       b_clear_req, b_busy, b_req_valid, b_req_ready, b_req_we;
  logic [7:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic       b_rsp_valid, b_rsp_err;

  memoria_dados_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) u_dut (
    .clk(clk), .clr(clr), .clear_req(clear_req), .busy(busy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  memoria_dados_param #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) u_dut_b (
    .clk(clk), .clr(clr), .clear_req(b_clear_req), .busy(b_busy),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted request on the 256-deep instance, checked in the next cycle.
  task automatic xfer(input string name, input logic we, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] exp_rdata,
                      input logic exp_err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    check({name, "_valid"}, rsp_valid, 1'b1);
    check({name, "_rdata"}, rsp_rdata, exp_rdata);
    check({name, "_err"}, rsp_err, exp_err);
  endtask

  // Count cycles until busy drops on the 256-deep instance (bounded).
  task automatic wait_clear(input string name, input int exp_len);
    int n         = 0;
    int bad_valid = 0;
    int bad_ready = 0;
    while (busy && n < 1000) begin
      if (rsp_valid) bad_valid++;
      if (req_ready) bad_ready++;
      step();
      n++;
    end
    check({name, "_len"}, n, exp_len);
    check({name, "_rsp_valid_cycles"}, bad_valid, 0);
    check({name, "_ready_cycles"}, bad_ready, 0);
    check({name, "_rsp_valid_end"}, rsp_valid, 1'b0);
    check({name, "_ready_end"}, req_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Range vectors for the DEPTH=200 instance (memory freshly cleared).
    tbl[0] = '{1'b1, 8'd210, 8'hAA, 8'h00, OOR_ERR};
    tbl[1] = '{1'b0, 8'd210, 8'h00, 8'h00, OOR_ERR};
    tbl[2] = '{1'b1, 8'd199, 8'h55, 8'h55, 1'b0};
    tbl[3] = '{1'b0, 8'd199, 8'h00, 8'h55, 1'b0};
    tbl[4] = '{1'b0, 8'd0,   8'h00, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 8'd255, 8'hFF, 8'h00, OOR_ERR};
    tbl[6] = '{1'b0, 8'd200, 8'h00, 8'h00, OOR_ERR};
    tbl[7] = '{1'b1, 8'd0,   8'h12, 8'h12, 1'b0};
    tbl[8] = '{1'b0, 8'd0,   8'h00, 8'h12, 1'b0};
    tbl[9] = '{1'b0, 8'd72,  8'h00, 8'h00, 1'b0};

    clr = 1'b0;
    clear_req = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    b_clear_req = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    repeat (3) step();

    // Reset values.
    check("rst_busy", busy, 1'b1);
    check("rst_ready", req_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rsp_rdata, 8'h00);
    check("rst_err", rsp_err, 1'b0);
    check("rst_b_busy", b_busy, 1'b1);

    // Release reset with a write request pending: it must not be taken while clearing.
    clr = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h80; req_wdata = 8'h77;
    wait_clear("clear_after_reset", 256);
    check("b_clear_done", b_busy, 1'b0);

    xfer("rd_00", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    xfer("rd_80", 1'b0, 8'h80, 8'h00, 8'h00, 1'b0);
    xfer("rd_ff", 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);

    // Fill back-to-back, then read back back-to-back.
    for (int i = 0; i < 256; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 8'(i); req_wdata = 8'(i + 1);
      exp_q.push_back(8'(i + 1));
      step();
      check("fill_wr_valid", rsp_valid, 1'b1);
      if (rsp_valid && exp_q.size() > 0) check("fill_wr_echo", rsp_rdata, exp_q.pop_front());
    end
    for (int i = 0; i < 256; i++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 8'(i); req_wdata = 8'h00;
      exp_q.push_back(8'(i + 1));
      step();
      check("fill_rd_valid", rsp_valid, 1'b1);
      if (rsp_valid && exp_q.size() > 0) check("fill_rd_data", rsp_rdata, exp_q.pop_front());
    end
    req_valid = 1'b0;
    step();
    check("fill_idle_valid", rsp_valid, 1'b0);
    check("fill_queue_empty", exp_q.size(), 0);

    // Write then read the same address on consecutive cycles; data holds after.
    xfer("wr_10", 1'b1, 8'h10, 8'h3C, 8'h3C, 1'b0);
    xfer("rd_10", 1'b0, 8'h10, 8'h00, 8'h3C, 1'b0);
    req_valid = 1'b0;
    step();
    check("hold_valid", rsp_valid, 1'b0);
    check("hold_rdata", rsp_rdata, 8'h3C);

    // On-demand clear with a read pending; 0x42 held 0x43 from the fill.
    clear_req = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h42;
    #1;
    check("clreq_ready_low", req_ready, 1'b0);
    check("clreq_busy_idle", busy, 1'b0);
    step();
    check("clreq_no_accept", rsp_valid, 1'b0);
    check("clreq_busy", busy, 1'b1);
    clear_req = 1'b0;
    wait_clear("clear_on_demand", 256);
    xfer("rd_42_cleared", 1'b0, 8'h42, 8'h00, 8'h00, 1'b0);
    xfer("rd_10_cleared", 1'b0, 8'h10, 8'h00, 8'h00, 1'b0);
    req_valid = 1'b0;

    // Range table on the DEPTH=200 instance.
    check("b_ready", b_req_ready, 1'b1);
    for (int k = 0; k < 10; k++) begin
      b_req_valid = 1'b1; b_req_we = tbl[k].we; b_req_addr = tbl[k].addr; b_req_wdata = tbl[k].wdata;
      step();
      check($sformatf("range%0d_valid", k), b_rsp_valid, 1'b1);
      check($sformatf("range%0d_rdata", k), b_rsp_rdata, tbl[k].exp_rdata);
      check($sformatf("range%0d_err", k), b_rsp_err, tbl[k].exp_err);
    end
    b_req_valid = 1'b0;
    step();
    check("range_idle_valid", b_rsp_valid, 1'b0);

    // In-flight response dropped by reset, then reset in the middle of a clear.
    xfer("wr_05", 1'b1, 8'h05, 8'h99, 8'h99, 1'b0);
    req_valid = 1'b0;
    clr = 1'b0;
    #1;
    check("drop_rsp_valid", rsp_valid, 1'b0);
    check("drop_busy", busy, 1'b1);
    check("drop_ready", req_ready, 1'b0);
    repeat (2) step();
    clr = 1'b1;
    begin
      int bad = 0;
      for (int c = 0; c < 100; c++) begin
        step();
        if (!busy || rsp_valid) bad++;
      end
      check("midclear_first100", bad, 0);
    end
    clr = 1'b0;
    #1;
    check("midclear_busy", busy, 1'b1);
    check("midclear_rsp_valid", rsp_valid, 1'b0);
    step();
    clr = 1'b1;
    wait_clear("clear_restart", 256);
    xfer("rd_05_cleared", 1'b0, 8'h05, 8'h00, 8'h00, 1'b0);
    req_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memoria_dados_param.md
# memoria_dados_param

Parametrised single-port data memory with a request/response handshake and a built-in sequential clear engine. Replaces the fixed 8x256 data memory in the datapath: load/store unit issues one request per cycle, gets a registered response one cycle later. Memory is zeroed by hardware after reset and on demand, one word per clock, never in zero time.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of words; 1 <= DEPTH <= 2**ADDR_W
- clk  input  1  clock, all state on rising edge
- clr  input  1  asynchronous active-low reset
- clear_req  input  1  synchronous request to re-zero the whole memory
- busy  output  1  high while clear engine is running
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request this cycle
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  one-cycle pulse, response for accepted request
- rsp_rdata  output  DATA_W  read data / echoed write data
- rsp_err  output  1  address out of range (see Configuration)

## Operation
- States: CLEAR, IDLE. clr low forces CLEAR, clear counter = 0, from any state, immediately.
- CLEAR: each rising edge writes 0 to mem[cnt], cnt++. Edge that writes DEPTH-1 moves to IDLE. busy = 1, req_ready = 0. clear_req ignored in CLEAR (no restart).
- IDLE: busy = 0. req_ready = ~clear_req (combinational). clear_req = 1 in IDLE: no request accepted that cycle; next edge -> CLEAR, cnt = 0.
- Accept = req_valid & req_ready, sampled at rising edge.
- Accepted read, addr < DEPTH: rsp_rdata = mem[addr] (contents before this edge), rsp_err = 0.
- Accepted write, addr < DEPTH: mem[addr] = req_wdata; rsp_rdata = req_wdata (echo), rsp_err = 0.
- Out-of-range (addr >= DEPTH): memory unchanged, rsp_rdata = 0, rsp_err per Configuration.
- No response back-pressure: consumer must take rsp in the cycle rsp_valid is high.
- rsp_rdata/rsp_err hold last value when rsp_valid = 0; not cleared by clear engine.

## Timing
- Reset values: busy = 1, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- After clr rises: exactly DEPTH rising edges of CLEAR; req_ready high from the cycle after the DEPTH-th edge (if clear_req low).
- Latency: request accepted at edge N -> rsp_valid high between edge N and N+1. Throughput one request per cycle, back-to-back.
- Read following write to same address on next cycle returns the new data.
- rsp_valid low on every edge with no accept, including all CLEAR cycles.
- clr asserted mid-clear or mid-traffic: in-flight response dropped (rsp_valid -> 0), clear restarts at address 0.
- clear_req asserted DEPTH cycles is one clear; holding it high after returning to IDLE starts another.

## Configuration
- MEMORIA_RANGE_CHECK_EN defined: out-of-range accepted request gives rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Not defined: rsp_err tied 0; out-of-range writes dropped silently, reads return 0, rsp_valid still pulses.
- In-range behaviour identical in both builds.

## Test plan
- Reset/clear: DEPTH=256, release clr -> busy = 1 for 256 cycles, req_ready = 1 on cycle 257; read addr 0x00, 0x80, 0xFF -> rsp_rdata 0x00.
- Fill and read-back: write addr i data i+1 for i = 0..255 back-to-back, then read all -> rsp_rdata = i+1, each rsp_valid one cycle after accept, no gaps.
- Write-then-read same address: write 0x3C to 0x10, read 0x10 next cycle -> rsp_rdata 0x3C; write response echoes 0x3C.
- On-demand clear: after fill, pulse clear_req in IDLE with req_valid high -> request not accepted, busy = 1 for 256 cycles, subsequent read 0x42 -> 0x00.
- Range: DEPTH=200, write 0xAA to addr 210 then read 210 -> rsp_rdata 0x00, rsp_err = 1 (macro on) / 0 (macro off); addr 199 write/read 0x55 -> 0x55, err 0.
- Reset mid-clear: drop clr at clear cycle 100 -> busy stays 1, full 256-cycle clear repeats after release, rsp_valid never high during it.
